// File: rtl/dma_pkg.sv
// dma_pkg: shared state enum, beat layout and default widths for the DMA signal slice
package dma_pkg;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_NCH = 2;
  localparam int DEF_CNT_W = 8;
  typedef enum logic {IDLE, BURST} state_t;
  typedef struct packed {
    logic eob;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_NCH-1:0] trans;
  } beat_t;
endpackage

// File: rtl/dma_skid_buf.sv
// dma_skid_buf: 2-entry valid/ready skid buffer; main drives the outputs, skid absorbs one beat of back-pressure
module dma_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [W-1:0] data_out
);
  logic main_v, skid_v, accept, load;
  logic [W-1:0] main_d, skid_d;
  assign accept = valid_in && ready_out;
  assign load = !main_v || ready_in;
  assign valid_out = main_v;
  assign data_out = main_d;
  // ready_out low implies skid full, so an accept never coincides with a skid refill of main
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
      ready_out <= 1'b0;
    end else if (load) begin
      main_v <= skid_v || accept;
      main_d <= skid_v ? skid_d : accept ? data_in : main_d;
      skid_v <= 1'b0;
      ready_out <= 1'b1;
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_d <= data_in;
      ready_out <= 1'b0;
    end else begin
      ready_out <= !skid_v;
    end
  end
endmodule

// File: rtl/dma_signal_slice.sv
// dma_signal_slice: DMA command register slice with burst framing, channel lock and beat counting; DMA_SIG_ONEHOT_CHK_EN drops non-one-hot beats
module dma_signal_slice
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NCH = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              end_in,
  input  logic [NCH-1:0]    act_in,
  input  logic [ADDR_W-1:0] addr_com,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              end_out,
  output logic [ADDR_W-1:0] addr_ram,
  output logic [NCH-1:0]    trans,
  output logic              busy,
  output logic [CNT_W-1:0]  burst_len,
  output logic              err
);
  localparam int PW = 1 + ADDR_W + NCH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [NCH-1:0] lock_ch, fwd_ch;
  logic accept, drop;
  logic [PW-1:0] out_d;
  assign accept = valid_in && ready_out;
`ifdef DMA_SIG_ONEHOT_CHK_EN
  assign drop = accept && ($countones(act_in) != 1);
`else
  assign drop = 1'b0;
`endif
  assign fwd_ch = state == BURST ? lock_ch : act_in;
  assign cnt_inc = (drop || cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign busy = state == BURST;
  assign {end_out, addr_ram, trans} = out_d;
  dma_skid_buf #(.W(PW)) u_buf (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in && !drop),
    .ready_out(ready_out),
    .data_in({end_in, addr_com, fwd_ch}),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .data_out(out_d)
  );
  // a dropped beat may close a burst but never opens one or reports a length from IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lock_ch <= '0;
      burst_len <= '0;
      err <= 1'b0;
    end else begin
      err <= accept && (drop || (state == BURST && act_in != lock_ch));
      if (accept) begin
        if (end_in) begin
          if (state == BURST || !drop) burst_len <= cnt_inc;
          state <= IDLE;
          cnt <= '0;
        end else if (state == BURST) begin
          cnt <= cnt_inc;
        end else if (!drop) begin
          state <= BURST;
          lock_ch <= act_in;
          cnt <= cnt_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_dma_signal_slice.sv
// tb_dma_signal_slice: vector table, directed corner sequences and random traffic against a queue-based reference model
module tb_dma_signal_slice;
  logic clk = 0, reset = 1, valid_in = 0, ready_in = 0, end_in = 0;
  logic [1:0] act_in = 0;
  logic [63:0] addr_com = 0;
  logic ready_out, valid_out, end_out, busy, err;
  logic [63:0] addr_ram;
  logic [1:0] trans;
  logic [7:0] burst_len;
  logic ready_out2, valid_out2, end_out2, busy2, err2;
  logic [63:0] addr_ram2;
  logic [1:0] trans2;
  logic [1:0] burst_len2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dma_signal_slice u0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out), .end_in(end_in),
    .act_in(act_in), .addr_com(addr_com), .valid_out(valid_out), .ready_in(ready_in),
    .end_out(end_out), .addr_ram(addr_ram), .trans(trans), .busy(busy),
    .burst_len(burst_len), .err(err));
  dma_signal_slice #(.CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out2), .end_in(end_in),
    .act_in(act_in), .addr_com(addr_com), .valid_out(valid_out2), .ready_in(ready_in),
    .end_out(end_out2), .addr_ram(addr_ram2), .trans(trans2), .busy(busy2),
    .burst_len(burst_len2), .err(err2));
  typedef struct {logic e; logic [63:0] a; logic [1:0] t;} mbeat_t;
  mbeat_t q[$];
  logic m_ready = 0, m_open = 0, m_err = 0;
  logic [1:0] m_lock = 0;
  int m_cnt = 0, m_len = 0;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, got, want, $time);
    end
  endtask
  task automatic model();
    logic acc, drop;
    if (reset) begin
      q.delete();
      m_ready = 0; m_open = 0; m_err = 0; m_cnt = 0; m_len = 0;
      return;
    end
    acc = valid_in && m_ready;
`ifdef DMA_SIG_ONEHOT_CHK_EN
    drop = acc && ($countones(act_in) != 1);
`else
    drop = 0;
`endif
    if (q.size() > 0 && ready_in) void'(q.pop_front());
    m_err = acc && (drop || (m_open && act_in != m_lock));
    if (acc && !drop) q.push_back('{end_in, addr_com, m_open ? m_lock : act_in});
    if (acc) begin
      if (!drop) m_cnt++;
      if (end_in) begin
        if (m_open || !drop) m_len = m_cnt;
        m_open = 0;
        m_cnt = 0;
      end else if (!drop && !m_open) begin
        m_open = 1;
        m_lock = act_in;
      end
    end
    m_ready = q.size() < 2;
  endtask
  task automatic check_all();
    chk("valid_out", valid_out, q.size() > 0);
    if (q.size() > 0) begin
      chk("addr_ram", addr_ram, q[0].a);
      chk("end_out", end_out, q[0].e);
      chk("trans", trans, q[0].t);
    end
    chk("ready_out", ready_out, m_ready);
    chk("busy", busy, m_open);
    chk("err", err, m_err);
    chk("burst_len", burst_len, m_len > 255 ? 255 : m_len);
    chk("burst_len_sat", burst_len2, m_len > 3 ? 3 : m_len);
  endtask
  task automatic step();
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic drive(input logic v, input logic r, input logic e, input logic [1:0] a, input logic [63:0] ad);
    valid_in = v; ready_in = r; end_in = e; act_in = a; addr_com = ad;
  endtask
  typedef struct {
    logic v, r, e; logic [1:0] a; logic [63:0] ad;
    logic xv, xe, xb, xerr; logic [1:0] xt; logic [63:0] xad; logic [7:0] xlen;
  } vec_t;
  vec_t tbl[10];
  initial begin
    tbl[0] = '{1, 1, 0, 2'b01, 64'h10, 1, 0, 1, 0, 2'b01, 64'h10, 8'd0};
    tbl[1] = '{1, 1, 0, 2'b01, 64'h11, 1, 0, 1, 0, 2'b01, 64'h11, 8'd0};
    tbl[2] = '{1, 1, 0, 2'b01, 64'h12, 1, 0, 1, 0, 2'b01, 64'h12, 8'd0};
    tbl[3] = '{1, 1, 1, 2'b01, 64'h13, 1, 1, 0, 0, 2'b01, 64'h13, 8'd4};
    tbl[4] = '{0, 1, 0, 2'b01, 64'h0, 0, 0, 0, 0, 2'b00, 64'h0, 8'd4};
    tbl[5] = '{1, 1, 0, 2'b10, 64'h20, 1, 0, 1, 0, 2'b10, 64'h20, 8'd4};
    tbl[6] = '{1, 1, 1, 2'b01, 64'h21, 1, 1, 0, 1, 2'b10, 64'h21, 8'd2};
    tbl[7] = '{0, 1, 0, 2'b01, 64'h0, 0, 0, 0, 0, 2'b00, 64'h0, 8'd2};
    tbl[8] = '{1, 1, 1, 2'b01, 64'h30, 1, 1, 0, 0, 2'b01, 64'h30, 8'd1};
    tbl[9] = '{0, 1, 0, 2'b01, 64'h0, 0, 0, 0, 0, 2'b00, 64'h0, 8'd1};
    drive(1, 1, 0, 2'b01, 64'hAA);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid_out", valid_out, 0);
      chk("rst_end_out", end_out, 0);
      chk("rst_addr_ram", addr_ram, 0);
      chk("rst_trans", trans, 0);
      chk("rst_busy", busy, 0);
      chk("rst_burst_len", burst_len, 0);
      chk("rst_err", err, 0);
      chk("rst_ready_out", ready_out, 0);
    end
    reset = 0;
    step();
    chk("post_rst_ready", ready_out, 1);
    chk("post_rst_valid", valid_out, 0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].ad);
      step();
      chk("tbl_valid", valid_out, tbl[i].xv);
      if (tbl[i].xv) begin
        chk("tbl_addr", addr_ram, tbl[i].xad);
        chk("tbl_end", end_out, tbl[i].xe);
        chk("tbl_trans", trans, tbl[i].xt);
      end
      chk("tbl_busy", busy, tbl[i].xb);
      chk("tbl_err", err, tbl[i].xerr);
      chk("tbl_len", burst_len, tbl[i].xlen);
    end
    drive(1, 0, 0, 2'b01, 64'h40); step();
    drive(1, 0, 0, 2'b01, 64'h41); step();
    chk("bp_ready_low", ready_out, 0);
    drive(1, 0, 1, 2'b01, 64'h42); step();
    chk("bp_hold_addr", addr_ram, 64'h40);
    chk("bp_hold_valid", valid_out, 1);
    drive(1, 1, 1, 2'b01, 64'h42); step();
    chk("bp_drain1", addr_ram, 64'h41);
    step();
    chk("bp_drain2", addr_ram, 64'h42);
    drive(0, 1, 0, 2'b01, 64'h0); step();
    chk("bp_len", burst_len, 3);
    chk("bp_empty", valid_out, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, i == 4, 2'b01, 64'h60 + i);
      step();
    end
    chk("sat_len2", burst_len2, 3);
    chk("sat_len8", burst_len, 5);
    drive(1, 1, 0, 2'b01, 64'h50); step();
    drive(1, 1, 0, 2'b11, 64'h51); step();
    chk("oh_err", err, 1);
`ifdef DMA_SIG_ONEHOT_CHK_EN
    chk("oh_dropped", valid_out, 0);
`else
    chk("oh_fwd_trans", trans, 2'b01);
`endif
    drive(1, 1, 1, 2'b01, 64'h52); step();
    chk("oh_last", addr_ram, 64'h52);
`ifdef DMA_SIG_ONEHOT_CHK_EN
    chk("oh_len", burst_len, 2);
`else
    chk("oh_len", burst_len, 3);
`endif
    drive(0, 1, 0, 2'b00, 64'h0); step();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            2'($urandom), {$urandom, $urandom});
      step();
    end
    reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
